// File: rtl/axi_lite_master.sv
// AXI4-Lite master. It accepts one command at a time on a valid/ready port,
// runs it as a single AXI4-Lite read or write, and returns the result on a
// valid/ready response port. A sticky watchdog flag reports a stalled slave
// but never abandons the transaction.
module axi_lite_master #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    // command port
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_write,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [DATA_WIDTH-1:0] i_cmd_wdata,
    // response port
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic [1:0]            o_rsp_resp,
    output logic                  o_rsp_write,
    // AXI write channels
    output logic                  o_awvalid,
    output logic [ADDR_WIDTH-1:0] o_awaddr,
    input  logic                  i_awready,
    output logic                  o_wvalid,
    output logic [DATA_WIDTH-1:0] o_wdata,
    input  logic                  i_wready,
    input  logic                  i_bvalid,
    output logic                  o_bready,
    input  logic [1:0]            i_bresp,
    // AXI read channels
    output logic                  o_arvalid,
    output logic [ADDR_WIDTH-1:0] o_araddr,
    input  logic                  i_arready,
    input  logic                  i_rvalid,
    output logic                  o_rready,
    input  logic [1:0]            i_rresp,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    // status
    output logic                  o_busy,
    output logic                  o_timeout
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RSP
    } state_t;

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  aw_done;
    logic                  w_done;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic [1:0]            rsp_resp_q;
    logic                  rsp_write_q;
    logic [CNT_W-1:0]      wdog_cnt;
    logic                  timeout_q;
    logic                  cmd_accept;
    logic                  busy_next;

    // A command is only taken in IDLE and never while reset is held.
    assign cmd_accept = (state == IDLE) & ~rst & i_cmd_valid;

    // The watchdog counts cycles that are about to be spent waiting on the slave.
    assign busy_next = (state_next == WR_REQ) || (state_next == WR_RESP) ||
                       (state_next == RD_REQ) || (state_next == RD_RESP);

    assign o_awaddr    = addr_q;
    assign o_araddr    = addr_q;
    assign o_wdata     = wdata_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_resp  = rsp_resp_q;
    assign o_rsp_write = rsp_write_q;
    assign o_timeout   = timeout_q;

    // State register; reset forces IDLE immediately, which drops every valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs, all decoded from the current state.
    always_comb begin
        state_next  = state;
        o_cmd_ready = 1'b0;
        o_awvalid   = 1'b0;
        o_wvalid    = 1'b0;
        o_bready    = 1'b0;
        o_arvalid   = 1'b0;
        o_rready    = 1'b0;
        o_rsp_valid = 1'b0;
        o_busy      = 1'b1;
        case (state)
            IDLE: begin
                o_cmd_ready = ~rst;
                o_busy      = 1'b0;
                if (cmd_accept) begin
                    state_next = i_cmd_write ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                o_awvalid = ~aw_done;
                o_wvalid  = ~w_done;
                if ((aw_done | i_awready) & (w_done | i_wready)) begin
                    state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                o_bready = 1'b1;
                if (i_bvalid) begin
                    state_next = RSP;
                end
            end
            RD_REQ: begin
                o_arvalid = 1'b1;
                if (i_arready) begin
                    state_next = RD_RESP;
                end
            end
            RD_RESP: begin
                o_rready = 1'b1;
                if (i_rvalid) begin
                    state_next = RSP;
                end
            end
            RSP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                o_busy     = 1'b0;
            end
        endcase
    end

    // Command capture, per-channel write handshake tracking and response capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            rsp_data_q  <= '0;
            rsp_resp_q  <= 2'b00;
            rsp_write_q <= 1'b0;
        end else begin
            if (cmd_accept) begin
                addr_q  <= i_cmd_addr;
                wdata_q <= i_cmd_wdata;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (state == WR_REQ) begin
                if (i_awready) begin
                    aw_done <= 1'b1;
                end
                if (i_wready) begin
                    w_done <= 1'b1;
                end
            end
            if ((state == WR_RESP) && i_bvalid) begin
                rsp_data_q  <= '0;
                rsp_resp_q  <= i_bresp;
                rsp_write_q <= 1'b1;
            end
            if ((state == RD_RESP) && i_rvalid) begin
                rsp_data_q  <= i_rdata;
                rsp_resp_q  <= i_rresp;
                rsp_write_q <= 1'b0;
            end
        end
    end

    // Saturating stall watchdog; the flag is sticky until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_next == IDLE) begin
                wdog_cnt <= '0;
            end else if (busy_next && (wdog_cnt != CNT_MAX)) begin
                wdog_cnt <= wdog_cnt + 1'b1;
            end
            if (busy_next && (wdog_cnt == CNT_TRIP)) begin
                timeout_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed testbench for axi_lite_master: the bench plays the AXI slave
// cycle by cycle and keeps expected responses in a scoreboard queue.
module tb_axi_lite_master;

    logic        clk;
    logic        rst;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic        i_cmd_write;
    logic [15:0] i_cmd_addr;
    logic [31:0] i_cmd_wdata;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_data;
    logic [1:0]  o_rsp_resp;
    logic        o_rsp_write;
    logic        o_awvalid;
    logic [15:0] o_awaddr;
    logic        i_awready;
    logic        o_wvalid;
    logic [31:0] o_wdata;
    logic        i_wready;
    logic        i_bvalid;
    logic        o_bready;
    logic [1:0]  i_bresp;
    logic        o_arvalid;
    logic [15:0] o_araddr;
    logic        i_arready;
    logic        i_rvalid;
    logic        o_rready;
    logic [1:0]  i_rresp;
    logic [31:0] i_rdata;
    logic        o_busy;
    logic        o_timeout;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        wr;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    axi_lite_master #(
        .ADDR_WIDTH    (16),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(256)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_cmd_valid(i_cmd_valid),
        .o_cmd_ready(o_cmd_ready),
        .i_cmd_write(i_cmd_write),
        .i_cmd_addr (i_cmd_addr),
        .i_cmd_wdata(i_cmd_wdata),
        .o_rsp_valid(o_rsp_valid),
        .i_rsp_ready(i_rsp_ready),
        .o_rsp_data (o_rsp_data),
        .o_rsp_resp (o_rsp_resp),
        .o_rsp_write(o_rsp_write),
        .o_awvalid  (o_awvalid),
        .o_awaddr   (o_awaddr),
        .i_awready  (i_awready),
        .o_wvalid   (o_wvalid),
        .o_wdata    (o_wdata),
        .i_wready   (i_wready),
        .i_bvalid   (i_bvalid),
        .o_bready   (o_bready),
        .i_bresp    (i_bresp),
        .o_arvalid  (o_arvalid),
        .o_araddr   (o_araddr),
        .i_arready  (i_arready),
        .i_rvalid   (i_rvalid),
        .o_rready   (o_rready),
        .i_rresp    (i_rresp),
        .i_rdata    (i_rdata),
        .o_busy     (o_busy),
        .o_timeout  (o_timeout)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence itself ever wedges.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One comparison point.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one command, push its expected response and return in cycle 1.
    task automatic applyStimulus(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] exp_data, input logic [1:0] exp_resp);
        for (int n = 0; n < 20 && o_cmd_ready !== 1'b1; n++) tick();
        checkOutput("cmd_ready_before_cmd", o_cmd_ready, 1);
        i_cmd_valid = 1'b1;
        i_cmd_write = wr;
        i_cmd_addr  = addr;
        i_cmd_wdata = wdata;
        sb.push_back('{data: exp_data, resp: exp_resp, wr: wr});
        tick();
        i_cmd_valid = 1'b0;
        i_cmd_wdata = 32'h0;
        i_cmd_addr  = 16'h0;
    endtask

    // Wait (bounded) for a response, compare against the scoreboard, then consume it.
    task automatic waitResponse(input string tag);
        exp_t e;
        logic [31:0] held_data;
        for (int n = 0; n < 20 && o_rsp_valid !== 1'b1; n++) tick();
        checkOutput({tag, "_rsp_valid"}, o_rsp_valid, 1);
        if (o_rsp_valid === 1'b1) begin
            checkOutput({tag, "_sb_nonempty"}, (sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput({tag, "_data"}, o_rsp_data, e.data);
                checkOutput({tag, "_resp"}, o_rsp_resp, e.resp);
                checkOutput({tag, "_write"}, o_rsp_write, e.wr);
            end
            checkOutput({tag, "_cmd_ready_in_rsp"}, o_cmd_ready, 0);
            held_data = o_rsp_data;
            tick();
            checkOutput({tag, "_rsp_held"}, o_rsp_valid, 1);
            checkOutput({tag, "_data_stable"}, o_rsp_data, held_data);
            i_rsp_ready = 1'b1;
            tick();
            i_rsp_ready = 1'b0;
            checkOutput({tag, "_rsp_dropped"}, o_rsp_valid, 0);
            checkOutput({tag, "_idle_gap_ready"}, o_cmd_ready, 1);
            checkOutput({tag, "_idle_busy"}, o_busy, 0);
        end
    endtask

    initial begin
        logic seen;
        rst         = 1'b1;
        i_cmd_valid = 1'b0;
        i_cmd_write = 1'b0;
        i_cmd_addr  = 16'h0;
        i_cmd_wdata = 32'h0;
        i_rsp_ready = 1'b0;
        i_awready   = 1'b0;
        i_wready    = 1'b0;
        i_bvalid    = 1'b0;
        i_bresp     = 2'b00;
        i_arready   = 1'b0;
        i_rvalid    = 1'b0;
        i_rresp     = 2'b00;
        i_rdata     = 32'h0;

        // Reset state.
        tick();
        checkOutput("rst_cmd_ready", o_cmd_ready, 0);
        checkOutput("rst_valids", {o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready, o_rsp_valid}, 0);
        checkOutput("rst_busy", o_busy, 0);
        checkOutput("rst_timeout", o_timeout, 0);
        checkOutput("rst_addr_data", {o_awaddr, o_araddr, o_wdata}, 0);
        checkOutput("rst_rsp_fields", {o_rsp_data, o_rsp_resp, o_rsp_write}, 0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_cmd_ready", o_cmd_ready, 1);

        // Zero-wait write: AW/W at cycle 1, B at cycle 2, response at cycle 3.
        $display("[TB] zero-wait write");
        i_awready = 1'b1;
        i_wready  = 1'b1;
        applyStimulus(1'b1, 16'h0000, 32'h0000_0006, 32'h0, 2'b00);
        checkOutput("w1_c1_valids", {o_awvalid, o_wvalid}, 2'b11);
        checkOutput("w1_c1_awaddr", o_awaddr, 16'h0000);
        checkOutput("w1_c1_wdata", o_wdata, 32'h0000_0006);
        checkOutput("w1_c1_busy", o_busy, 1);
        tick();
        i_awready = 1'b0;
        i_wready  = 1'b0;
        checkOutput("w1_c2_valids", {o_awvalid, o_wvalid}, 2'b00);
        checkOutput("w1_c2_bready", o_bready, 1);
        checkOutput("w1_c2_rsp_valid", o_rsp_valid, 0);
        i_bvalid = 1'b1;
        i_bresp  = 2'b00;
        tick();
        i_bvalid = 1'b0;
        checkOutput("w1_c3_latency", o_rsp_valid, 1);
        waitResponse("w1");

        // Zero-wait read of 0x0010.
        $display("[TB] zero-wait read");
        i_arready = 1'b1;
        applyStimulus(1'b0, 16'h0010, 32'h0, 32'h0ca7_cafe, 2'b00);
        checkOutput("r1_c1_arvalid", o_arvalid, 1);
        checkOutput("r1_c1_araddr", o_araddr, 16'h0010);
        tick();
        i_arready = 1'b0;
        checkOutput("r1_c2_arvalid", o_arvalid, 0);
        checkOutput("r1_c2_rready", o_rready, 1);
        i_rvalid = 1'b1;
        i_rdata  = 32'h0ca7_cafe;
        i_rresp  = 2'b00;
        tick();
        i_rvalid = 1'b0;
        i_rdata  = 32'h0;
        checkOutput("r1_c3_latency", o_rsp_valid, 1);
        waitResponse("r1");

        // Write whose W handshakes 4 cycles before AW; bresp DECERR passes through.
        $display("[TB] split AW/W write");
        i_wready = 1'b1;
        applyStimulus(1'b1, 16'h0040, 32'hA5A5_5A5A, 32'h0, 2'b11);
        checkOutput("w2_c1_valids", {o_awvalid, o_wvalid}, 2'b11);
        tick();
        i_wready = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            checkOutput("w2_aw_held", {o_awvalid, o_wvalid, o_bready}, 3'b100);
            checkOutput("w2_awaddr_stable", o_awaddr, 16'h0040);
            tick();
        end
        i_awready = 1'b1;
        checkOutput("w2_c5_awvalid", o_awvalid, 1);
        tick();
        i_awready = 1'b0;
        checkOutput("w2_c6_bready", {o_awvalid, o_wvalid, o_bready}, 3'b001);
        i_bvalid = 1'b1;
        i_bresp  = 2'b11;
        tick();
        i_bvalid = 1'b0;
        i_bresp  = 2'b00;
        checkOutput("w2_c7_single_b", o_bready, 0);
        waitResponse("w2");
        checkOutput("w2_sb_drained", sb.size(), 0);

        // Read of 0x0020 with SLVERR and a delayed R beat.
        $display("[TB] slverr read");
        i_arready = 1'b1;
        applyStimulus(1'b0, 16'h0020, 32'h0, 32'hDEAD_BEEF, 2'b10);
        tick();
        i_arready = 1'b0;
        tick();
        checkOutput("r2_c3_waiting", {o_rready, o_rsp_valid}, 2'b10);
        i_rvalid = 1'b1;
        i_rdata  = 32'hDEAD_BEEF;
        i_rresp  = 2'b10;
        tick();
        i_rvalid = 1'b0;
        i_rdata  = 32'h0;
        i_rresp  = 2'b00;
        waitResponse("r2");

        // Slave stalls AR: watchdog fires at cycle 256, transaction continues.
        $display("[TB] watchdog");
        applyStimulus(1'b0, 16'h0030, 32'h0, 32'h1357_9BDF, 2'b01);
        repeat (254) tick();
        checkOutput("wd_c255_timeout", o_timeout, 0);
        tick();
        checkOutput("wd_c256_timeout", o_timeout, 1);
        checkOutput("wd_c256_arvalid", o_arvalid, 1);
        checkOutput("wd_c256_busy", o_busy, 1);
        repeat (10) tick();
        checkOutput("wd_sat_timeout", o_timeout, 1);
        checkOutput("wd_sat_arvalid", o_arvalid, 1);
        i_arready = 1'b1;
        tick();
        i_arready = 1'b0;
        i_rvalid  = 1'b1;
        i_rdata   = 32'h1357_9BDF;
        i_rresp   = 2'b01;
        tick();
        i_rvalid = 1'b0;
        i_rdata  = 32'h0;
        i_rresp  = 2'b00;
        waitResponse("wd");
        checkOutput("wd_sticky_in_idle", o_timeout, 1);

        // Reset in WR_RESP: everything drops at once, pending response discarded.
        $display("[TB] reset mid-transaction");
        i_awready = 1'b1;
        i_wready  = 1'b1;
        applyStimulus(1'b1, 16'h0060, 32'hCAFE_0001, 32'h0, 2'b00);
        tick();
        i_awready = 1'b0;
        i_wready  = 1'b0;
        checkOutput("mr_in_wr_resp", o_bready, 1);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        checkOutput("mr_bready_async", o_bready, 0);
        checkOutput("mr_busy_async", o_busy, 0);
        checkOutput("mr_rsp_valid", o_rsp_valid, 0);
        checkOutput("mr_timeout_cleared", o_timeout, 0);
        checkOutput("mr_addr_cleared", {o_awaddr, o_wdata}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("mr_cmd_ready_release", o_cmd_ready, 1);
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            seen = seen | o_rsp_valid | o_bready;
        end
        checkOutput("mr_no_stale_rsp", seen, 0);

        // Normal operation after the mid-transaction reset.
        $display("[TB] read after reset");
        i_arready = 1'b1;
        applyStimulus(1'b0, 16'h0050, 32'h0, 32'h1234_5678, 2'b00);
        tick();
        i_arready = 1'b0;
        i_rvalid  = 1'b1;
        i_rdata   = 32'h1234_5678;
        tick();
        i_rvalid = 1'b0;
        i_rdata  = 32'h0;
        waitResponse("r3");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
